// File: rtl/tv80_bus_bridge.sv
// TV80 bus bridge: turns Z80-style strobes into a single-outstanding req/ack fabric port,
// stretches the CPU through wait_n, answers INTA with a vector and times out hung accesses.
module tv80_bus_bridge #(
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [7:0]  FLOAT_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    input  logic [7:0]  int_vec,
    output logic        wait_n,
    output logic [7:0]  di,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_io_q, mem_io_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [7:0]    di_q, di_d;
    logic          bus_err_q, bus_err_d;
    logic          acc, inta;

    // Strobe decode and combinational wait: low in the very cycle a strobe first appears
    always_comb begin
        acc    = (~rd_n | ~wr_n) & (~mreq_n | ~iorq_n) & rfsh_n;
        inta   = ~m1_n & ~iorq_n;
        wait_n = reset | ~((acc | inta) & (state_q != StDone));
    end

    // Next-state and datapath updates for the IDLE/REQ/DONE handshake
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_io_d    = mem_io_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        di_d        = di_q;
        bus_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inta) begin
                    // INTA never reaches the fabric; the vector is returned locally
                    di_d    = int_vec;
                    state_d = StDone;
                end else if (acc) begin
                    mem_addr_d  = A;
                    mem_wdata_d = dout;
                    mem_we_d    = ~wr_n;
                    mem_io_d    = ~iorq_n;
                    mem_req_d   = 1'b1;
                    timer_d     = '0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                // Strobes are not consulted here: once issued, the handshake always completes
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) di_d = mem_rdata;
                    state_d = StDone;
                end else if (timer_q == TMAX) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) di_d = FLOAT_BYTE;
                    bus_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: begin
                if (mreq_n && iorq_n) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset that aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_io_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            di_q        <= FLOAT_BYTE;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_io_q    <= mem_io_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            di_q        <= di_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Registered outputs
    always_comb begin
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_io    = mem_io_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        di        = di_q;
        bus_err   = bus_err_q;
    end

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Directed bench for tv80_bus_bridge: inputs change on negedge, outputs sampled 1ns later.
module tb_tv80_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] A;
    logic [7:0]  dout, int_vec;
    logic        wait_n;
    logic [7:0]  di;
    logic        mem_req, mem_we, mem_io;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    tv80_bus_bridge #(.TIMEOUT(64), .FLOAT_BYTE(8'hFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .rfsh_n    (rfsh_n),
        .A         (A),
        .dout      (dout),
        .int_vec   (int_vec),
        .wait_n    (wait_n),
        .di        (di),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_io    (mem_io),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic idle_bus();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL rst_wait got=%b exp=1", wait_n); else n_pass++;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_we got=%b exp=0", mem_we); else n_pass++;
        n_checks++; if (mem_io !== 1'b0) $display("FAIL rst_io got=%b exp=0", mem_io); else n_pass++;
        n_checks++; if (mem_addr !== 16'h0) $display("FAIL rst_addr got=%h exp=0000", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 8'h0) $display("FAIL rst_wdata got=%h exp=00", mem_wdata); else n_pass++;
        n_checks++; if (di !== 8'hFF) $display("FAIL rst_di got=%h exp=ff", di); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus_err); else n_pass++;
        idle_bus();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mem_read();
        @(negedge clk);
        mreq_n = 1'b0; rd_n = 1'b0; A = 16'h1234;
        #1;
        n_checks++; if (wait_n !== 1'b0) $display("FAIL rd_wait0 got=%b exp=0", wait_n); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rd_req0 got=%b exp=0", mem_req); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 8'hA5; end
            #1;
            n_checks++; if (mem_req !== 1'b1) $display("FAIL rd_req%0d got=%b exp=1", i, mem_req); else n_pass++;
            n_checks++; if (mem_addr !== 16'h1234) $display("FAIL rd_addr%0d got=%h exp=1234", i, mem_addr); else n_pass++;
            n_checks++; if ({mem_we, mem_io} !== 2'b00) $display("FAIL rd_weio%0d got=%b exp=00", i, {mem_we, mem_io}); else n_pass++;
            n_checks++; if (wait_n !== 1'b0) $display("FAIL rd_wait%0d got=%b exp=0", i, wait_n); else n_pass++;
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rd_reqdone got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (di !== 8'hA5) $display("FAIL rd_di got=%h exp=a5", di); else n_pass++;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL rd_waitdone got=%b exp=1", wait_n); else n_pass++;
        idle_bus();
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rd_idle_req got=%b exp=0", mem_req); else n_pass++;
    endtask

    task automatic test_io_write();
        @(negedge clk);
        iorq_n = 1'b0; wr_n = 1'b0; A = 16'h00FE; dout = 8'h3C;
        #1;
        n_checks++; if (wait_n !== 1'b0) $display("FAIL wr_wait0 got=%b exp=0", wait_n); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h99;
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL wr_req got=%b exp=1", mem_req); else n_pass++;
        n_checks++; if ({mem_we, mem_io} !== 2'b11) $display("FAIL wr_weio got=%b exp=11", {mem_we, mem_io}); else n_pass++;
        n_checks++; if (mem_wdata !== 8'h3C) $display("FAIL wr_wdata got=%h exp=3c", mem_wdata); else n_pass++;
        n_checks++; if (mem_addr !== 16'h00FE) $display("FAIL wr_addr got=%h exp=00fe", mem_addr); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL wr_reqdone got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (di !== 8'hA5) $display("FAIL wr_di got=%h exp=a5", di); else n_pass++;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL wr_waitdone got=%b exp=1", wait_n); else n_pass++;
        idle_bus();
        @(negedge clk);
    endtask

    task automatic test_inta();
        @(negedge clk);
        m1_n = 1'b0; iorq_n = 1'b0; int_vec = 8'hD7;
        #1;
        n_checks++; if (wait_n !== 1'b0) $display("FAIL inta_wait0 got=%b exp=0", wait_n); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL inta_wait1 got=%b exp=1", wait_n); else n_pass++;
        n_checks++; if (di !== 8'hD7) $display("FAIL inta_di got=%h exp=d7", di); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL inta_req got=%b exp=0", mem_req); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL inta_wait2 got=%b exp=1", wait_n); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL inta_req2 got=%b exp=0", mem_req); else n_pass++;
        idle_bus();
        @(negedge clk);
    endtask

    task automatic test_refresh();
        @(negedge clk);
        mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (wait_n !== 1'b1) $display("FAIL rfsh_wait%0d got=%b exp=1", i, wait_n); else n_pass++;
            n_checks++; if (mem_req !== 1'b0) $display("FAIL rfsh_req%0d got=%b exp=0", i, mem_req); else n_pass++;
            @(negedge clk);
        end
        idle_bus();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        @(negedge clk);
        mreq_n = 1'b0; rd_n = 1'b0; A = 16'h4000;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (mem_req === 1'b1) hi++;
            else break;
        end
        n_checks++; if (hi != 64) $display("FAIL to_len got=%0d exp=64", hi); else n_pass++;
        n_checks++; if (bus_err !== 1'b1) $display("FAIL to_err got=%b exp=1", bus_err); else n_pass++;
        n_checks++; if (di !== 8'hFF) $display("FAIL to_di got=%h exp=ff", di); else n_pass++;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL to_wait got=%b exp=1", wait_n); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL to_errpulse got=%b exp=0", bus_err); else n_pass++;
        idle_bus();
        @(negedge clk);
        // Ack arriving exactly in the last timer cycle must win over the timeout
        @(negedge clk);
        mreq_n = 1'b0; rd_n = 1'b0; A = 16'h5000;
        repeat (63) @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL tb_req got=%b exp=1", mem_req); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL tb_reqdone got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (di !== 8'h5A) $display("FAIL tb_di got=%h exp=5a", di); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL tb_err got=%b exp=0", bus_err); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL tb_err2 got=%b exp=0", bus_err); else n_pass++;
        idle_bus();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req();
        int errs;
        errs = 0;
        @(negedge clk);
        mreq_n = 1'b0; rd_n = 1'b0; A = 16'h7777;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL mr_req got=%b exp=1", mem_req); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL mr_wait got=%b exp=1", wait_n); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        idle_bus();
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL mr_reqdrop got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (di !== 8'hFF) $display("FAIL mr_di got=%h exp=ff", di); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL mr_err got=%b exp=0", bus_err); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h33;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL stray_req got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (di !== 8'hFF) $display("FAIL stray_di got=%h exp=ff", di); else n_pass++;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            #1;
            if (bus_err !== 1'b0) errs++;
        end
        n_checks++; if (errs != 0) $display("FAIL mr_noerr got=%0d exp=0", errs); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mreq_n = 1'b0; rd_n = 1'b0; A = 16'h0001;
        #1;
        n_checks++; if (wait_n !== 1'b0) $display("FAIL bb_wait0 got=%b exp=0", wait_n); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL bb_req got=%b exp=1", mem_req); else n_pass++;
        n_checks++; if (wait_n !== 1'b0) $display("FAIL bb_wait1 got=%b exp=0", wait_n); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #1;
        n_checks++; if (di !== 8'h11) $display("FAIL bb_di got=%h exp=11", di); else n_pass++;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL bb_wait2 got=%b exp=1", wait_n); else n_pass++;
        idle_bus();
        @(negedge clk);
        mreq_n = 1'b0; wr_n = 1'b0; A = 16'h0002; dout = 8'h22;
        #1;
        n_checks++; if (wait_n !== 1'b0) $display("FAIL bb2_wait0 got=%b exp=0", wait_n); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL bb2_req got=%b exp=1", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b1) $display("FAIL bb2_we got=%b exp=1", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 16'h0002) $display("FAIL bb2_addr got=%h exp=0002", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 8'h22) $display("FAIL bb2_wdata got=%h exp=22", mem_wdata); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL bb2_reqdone got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (di !== 8'h11) $display("FAIL bb2_di got=%h exp=11", di); else n_pass++;
        n_checks++; if (wait_n !== 1'b1) $display("FAIL bb2_wait got=%b exp=1", wait_n); else n_pass++;
        idle_bus();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        A = 16'h0; dout = 8'h0; int_vec = 8'hFF;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        test_reset();
        test_mem_read();
        test_io_write();
        test_inta();
        test_refresh();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
